// File: rtl/core_run_monitor_if.sv
// core_run_monitor_if: run-control, halt and result signals between the bench/top level and core_run_monitor.
// Revision: 1.0
`default_nettype none

interface core_run_monitor_if #(
  parameter int NUM_CORES = 1,
  parameter int CYCLE_W   = 32
);
  logic                           start;
  logic [CYCLE_W-1:0]             timeout_limit;
  logic [NUM_CORES-1:0]           core_halt;
  logic [NUM_CORES-1:0]           core_rst_n;
  logic                           busy;
  logic                           done;
  logic                           timed_out;
  logic [NUM_CORES-1:0]           halted_mask;
  logic [CYCLE_W-1:0]             cycle_count;
  logic [NUM_CORES*CYCLE_W-1:0]   halt_cycles;

  modport master (
    output start, timeout_limit, core_halt,
    input  core_rst_n, busy, done, timed_out, halted_mask, cycle_count, halt_cycles
  );

  modport slave (
    input  start, timeout_limit, core_halt,
    output core_rst_n, busy, done, timed_out, halted_mask, cycle_count, halt_cycles
  );
endinterface

`default_nettype wire

// File: rtl/core_run_monitor.sv
// core_run_monitor: sequences core resets, counts run cycles, records first halts and enforces a timeout.
// Revision: 1.0
`default_nettype none

module core_run_monitor #(
  parameter int              NUM_CORES       = 1,
  parameter int              CYCLE_W         = 32,
  parameter int              RESET_CYCLES    = 3,
  parameter longint unsigned DEFAULT_TIMEOUT = 1000000
) (
  input  wire                  clk,
  input  wire                  rst,
  core_run_monitor_if.slave    bus
);

  localparam int                c_RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RESET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] c_DEF_LIM  = CYCLE_W'(DEFAULT_TIMEOUT);
  localparam logic [NUM_CORES-1:0] c_ALL    = {NUM_CORES{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [c_RST_W-1:0]           r_rst_cnt;
  logic [CYCLE_W-1:0]           r_limit;
  logic [CYCLE_W-1:0]           r_cycle_count;
  logic [NUM_CORES-1:0]         r_halted_mask;
  logic [NUM_CORES*CYCLE_W-1:0] r_halt_cycles;
  logic                         r_timed_out;
  logic                         r_done;

  logic                         w_accept;
  logic                         w_finish;
  logic                         w_all_halted;
  logic                         w_busy;
  logic                         w_cores_run;
  logic [NUM_CORES-1:0]         w_new_halt;

  assign w_new_halt   = bus.core_halt & ~r_halted_mask;
  assign w_all_halted = ((r_halted_mask | bus.core_halt) == c_ALL);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_busy      = 1'b0;
    w_cores_run = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RESET;
        end
      end
      S_RESET: begin
        w_busy = 1'b1;
        if (r_rst_cnt == c_RST_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        w_busy      = 1'b1;
        w_cores_run = 1'b1;
        if (w_all_halted || (r_cycle_count == r_limit - CYCLE_W'(1))) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        w_cores_run = 1'b1;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RESET;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_cnt     <= '0;
      r_limit       <= '0;
      r_cycle_count <= '0;
      r_halted_mask <= '0;
      r_halt_cycles <= '0;
      r_timed_out   <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_rst_cnt     <= '0;
        r_limit       <= (bus.timeout_limit == '0) ? c_DEF_LIM : bus.timeout_limit;
        r_cycle_count <= '0;
        r_halted_mask <= '0;
        r_halt_cycles <= '0;
        r_timed_out   <= 1'b0;
      end
      if (r_state == S_RESET) r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
      if (r_state == S_RUN) begin
        r_cycle_count <= r_cycle_count + CYCLE_W'(1);
        r_halted_mask <= r_halted_mask | bus.core_halt;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (w_new_halt[i]) r_halt_cycles[i*CYCLE_W +: CYCLE_W] <= r_cycle_count;
        end
        // Completion by halts wins over a timeout landing on the same cycle.
        if (w_finish) begin
          r_done      <= 1'b1;
          r_timed_out <= ~w_all_halted;
        end
      end
    end
  end

  assign bus.core_rst_n  = w_cores_run ? c_ALL : '0;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.timed_out   = r_timed_out;
  assign bus.halted_mask = r_halted_mask;
  assign bus.cycle_count = r_cycle_count;
  assign bus.halt_cycles = r_halt_cycles;

endmodule

`default_nettype wire

// File: tb/tb_core_run_monitor.sv
// tb_core_run_monitor: directed checks of core_run_monitor with one single-core and one four-core instance.
// Revision: 1.0
`default_nettype none

module tb_core_run_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  core_run_monitor_if #(.NUM_CORES(1), .CYCLE_W(32)) b1 ();
  core_run_monitor_if #(.NUM_CORES(4), .CYCLE_W(32)) b4 ();

  core_run_monitor #(.NUM_CORES(1), .CYCLE_W(32), .RESET_CYCLES(3), .DEFAULT_TIMEOUT(1000000)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  core_run_monitor #(.NUM_CORES(4), .CYCLE_W(32), .RESET_CYCLES(3), .DEFAULT_TIMEOUT(50)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  task automatic step(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch1(input logic [31:0] lim);
    b1.timeout_limit = lim;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
  endtask

  task automatic launch4(input logic [31:0] lim);
    b4.timeout_limit = lim;
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
  endtask

  initial begin
    b1.start = 1'b0; b1.timeout_limit = '0; b1.core_halt = '0;
    b4.start = 1'b0; b4.timeout_limit = '0; b4.core_halt = '0;
    step(2);
    rst = 1'b0;

    // Reset state
    chk("rst_rstn1",  b1.core_rst_n, 0);
    chk("rst_busy1",  b1.busy, 0);
    chk("rst_done1",  b1.done, 0);
    chk("rst_rstn4",  b4.core_rst_n, 0);
    chk("rst_mask4",  b4.halted_mask, 0);
    chk("rst_cnt4",   b4.cycle_count, 0);
    chk("rst_hc4",    b4.halt_cycles, 0);
    chk("rst_to4",    b4.timed_out, 0);

    // 1: single core, halt pulse at count 10
    launch1(32'd0);
    chk("t1_busy_reset", b1.busy, 1);
    n = 0;
    while (b1.core_rst_n == 1'b0 && n < 10) begin
      n++;
      step();
    end
    chk("t1_rstn_low_cycles", n, 3);
    chk("t1_run_cnt0", b1.cycle_count, 0);
    step(10);
    chk("t1_cnt10", b1.cycle_count, 10);
    b1.core_halt = 1'b1;
    step();
    b1.core_halt = 1'b0;
    chk("t1_done",   b1.done, 1);
    chk("t1_hc",     b1.halt_cycles, 10);
    chk("t1_cnt",    b1.cycle_count, 11);
    chk("t1_to",     b1.timed_out, 0);
    chk("t1_busy",   b1.busy, 0);
    step();
    chk("t1_done_pulse", b1.done, 0);
    chk("t1_rstn_done",  b1.core_rst_n, 1);
    chk("t1_hold_cnt",   b1.cycle_count, 11);

    // 2: timeout of 20, launched from DONE
    launch1(32'd20);
    chk("t2_cleared_hc", b1.halt_cycles, 0);
    step(3);
    step(19);
    chk("t2_cnt19_busy", b1.busy, 1);
    chk("t2_cnt19_done", b1.done, 0);
    step();
    chk("t2_done", b1.done, 1);
    chk("t2_to",   b1.timed_out, 1);
    chk("t2_cnt",  b1.cycle_count, 20);
    chk("t2_mask", b1.halted_mask, 0);

    // 3: four cores, halts at 5,9,9,30 with repeat on core0 at 12
    launch4(32'd100);
    step(3);
    for (int c = 0; c <= 30; c++) begin
      if (c == 20) begin
        chk("t3_mask_mid", b4.halted_mask, 4'h7);
        chk("t3_hc0_mid",  b4.halt_cycles[31:0], 5);
      end
      b4.core_halt = (c == 5) ? 4'h1 : (c == 9) ? 4'h6 : (c == 12) ? 4'h1 : (c == 30) ? 4'h8 : 4'h0;
      step();
    end
    b4.core_halt = 4'h0;
    chk("t3_done", b4.done, 1);
    chk("t3_mask", b4.halted_mask, 4'hF);
    chk("t3_hc",   b4.halt_cycles, {32'd30, 32'd9, 32'd9, 32'd5});
    chk("t3_cnt",  b4.cycle_count, 31);
    chk("t3_to",   b4.timed_out, 0);

    // 4: last halt coincides with limit
    launch4(32'd16);
    step(3);
    for (int c = 0; c <= 15; c++) begin
      b4.core_halt = (c == 2) ? 4'h7 : (c == 15) ? 4'h8 : 4'h0;
      step();
    end
    b4.core_halt = 4'h0;
    chk("t4_done", b4.done, 1);
    chk("t4_to",   b4.timed_out, 0);
    chk("t4_cnt",  b4.cycle_count, 16);
    chk("t4_hc",   b4.halt_cycles, {32'd15, 32'd2, 32'd2, 32'd2});

    // 5: reset mid-run then relaunch
    launch4(32'd100);
    step(3);
    step(7);
    chk("t5_cnt7", b4.cycle_count, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rstn", b4.core_rst_n, 0);
    chk("t5_busy", b4.busy, 0);
    chk("t5_done", b4.done, 0);
    chk("t5_cnt",  b4.cycle_count, 0);
    chk("t5_mask", b4.halted_mask, 0);
    launch4(32'd8);
    step(3);
    step(8);
    chk("t5_re_done", b4.done, 1);
    chk("t5_re_to",   b4.timed_out, 1);
    chk("t5_re_cnt",  b4.cycle_count, 8);

    // 6: default timeout, ignored start in RUN, relaunch from DONE
    launch4(32'd0);
    step(3);
    step(10);
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    chk("t6_ign_busy", b4.busy, 1);
    chk("t6_ign_cnt",  b4.cycle_count, 11);
    step(38);
    chk("t6_cnt49_done", b4.done, 0);
    step();
    chk("t6_done", b4.done, 1);
    chk("t6_to",   b4.timed_out, 1);
    chk("t6_cnt",  b4.cycle_count, 50);
    launch4(32'd0);
    chk("t6_re_busy", b4.busy, 1);
    chk("t6_re_cnt",  b4.cycle_count, 0);
    chk("t6_re_to",   b4.timed_out, 0);
    chk("t6_re_rstn", b4.core_rst_n, 0);
    b4.core_halt = 4'hF;
    step(2);
    b4.core_halt = 4'h0;
    step();
    chk("t6_reset_halt_ign", b4.halted_mask, 0);
    chk("t6_run_rstn",       b4.core_rst_n, 4'hF);
    b4.core_halt = 4'hF;
    step();
    b4.core_halt = 4'h0;
    chk("t6_all_done", b4.done, 1);
    chk("t6_all_cnt",  b4.cycle_count, 1);
    chk("t6_all_hc",   b4.halt_cycles, 0);
    chk("t6_all_mask", b4.halted_mask, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
